// File: rtl/calc_pkg.sv
// Shared encodings for the calculator key sequencer: key codes, FSM states,
// ALU op and display select values.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hC;
  localparam logic [3:0] KEY_CLR = 4'hD;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  localparam logic [1:0] DIGITS_MAX = 2'd3;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_START    = 3'd2,
    ST_WAIT_ALU = 3'd3,
    ST_SHOW     = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/calc_digit_reg.sv
// Three-digit BCD entry register: new digits shift in from the right, digits
// beyond the third are dropped.
module calc_digit_reg
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        shift,
  input  logic [3:0]  digit,
  output logic [11:0] value_q,
  output logic [1:0]  count_q
);

  logic [11:0] value_d;
  logic [1:0]  count_d;

  // Clear beats load beats shift.
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clear) begin
      value_d = 12'h000;
      count_d = 2'd0;
    end else if (load) begin
      value_d = {8'h00, digit};
      count_d = 2'd1;
    end else if (shift && (count_q != DIGITS_MAX)) begin
      value_d = {value_q[7:0], digit};
      count_d = count_q + 2'd1;
    end else begin
      value_d = value_q;
      count_d = count_q;
    end
  end

  // Digit and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 12'h000;
      count_q <= 2'd0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Key-entry sequencer for a 3-digit BCD calculator: collects operands, hands
// them to an external ALU, and latches the result or a timeout error.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  input  logic        alu_ovf,
  output logic        alu_start,
  output logic        alu_op,
  output logic [11:0] operand_a,
  output logic [11:0] operand_b,
  output logic [15:0] result_q,
  output logic [1:0]  display_sel,
  output logic        err,
  output logic        busy
);

  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [15:0] result_d;
  logic        err_q, err_d;
  logic [1:0]  disp_q, disp_d;
  logic [15:0] timer_q, timer_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        a_clear, a_load, a_shift, b_clear, b_shift;
  logic [1:0]  a_count, b_count;
  logic        key_digit, key_op, key_eq, key_clr;

  assign key_digit = key_valid & is_digit(key_code);
  assign key_op    = key_valid & ((key_code == KEY_ADD) | (key_code == KEY_SUB));
  assign key_eq    = key_valid & (key_code == KEY_EQ);
  assign key_clr   = key_valid & (key_code == KEY_CLR);

  calc_digit_reg u_reg_a (
    .clk(clk), .reset(reset), .clear(a_clear), .load(a_load), .shift(a_shift),
    .digit(key_code), .value_q(operand_a), .count_q(a_count)
  );

  calc_digit_reg u_reg_b (
    .clk(clk), .reset(reset), .clear(b_clear), .load(1'b0), .shift(b_shift),
    .digit(key_code), .value_q(operand_b), .count_q(b_count)
  );

  // Next-state and next-output logic; clear overrides everything, including a pending ALU reply.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    disp_d   = disp_q;
    timer_d  = timer_q;
    a_clear  = 1'b0;
    a_load   = 1'b0;
    a_shift  = 1'b0;
    b_clear  = 1'b0;
    b_shift  = 1'b0;
    if (key_clr) begin
      a_clear = 1'b1;
      b_clear = 1'b1;
      err_d   = 1'b0;
      op_d    = OP_ADD;
      disp_d  = DISP_A;
      timer_d = TIMEOUT_LD;
      state_d = ST_ENTER_A;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (key_digit) begin
            a_shift = (a_count != DIGITS_MAX);
          end else if (key_op) begin
            op_d    = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
            b_clear = 1'b1;
            state_d = ST_ENTER_B;
          end else begin
            state_d = ST_ENTER_A;
          end
        end
        ST_ENTER_B: begin
          if (key_digit) begin
            b_shift = (b_count != DIGITS_MAX);
            disp_d  = DISP_B;
          end else if (key_op && (b_count == 2'd0)) begin
            op_d = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
          end else if (key_eq) begin
            state_d = ST_START;
          end else begin
            state_d = ST_ENTER_B;
          end
        end
        ST_START: begin
          timer_d = TIMEOUT_LD;
          state_d = ST_WAIT_ALU;
        end
        ST_WAIT_ALU: begin
          if (alu_done) begin
            result_d = alu_result;
            err_d    = alu_ovf;
            disp_d   = DISP_RES;
            timer_d  = TIMEOUT_LD;
            state_d  = ST_SHOW;
          end else if (timer_q <= 16'd1) begin
            // Last waiting cycle: SHOW lands exactly TIMEOUT cycles after entry.
            result_d = 16'h0000;
            err_d    = 1'b1;
            disp_d   = DISP_RES;
            timer_d  = TIMEOUT_LD;
            state_d  = ST_SHOW;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        ST_SHOW: begin
          if (key_digit) begin
            a_load  = 1'b1;
            b_clear = 1'b1;
            err_d   = 1'b0;
            disp_d  = DISP_A;
            state_d = ST_ENTER_A;
          end else begin
            state_d = ST_SHOW;
          end
        end
        default: begin
          state_d = ST_ENTER_A;
        end
      endcase
    end
    start_d = (state_d == ST_START);
    busy_d  = (state_d == ST_START) || (state_d == ST_WAIT_ALU);
  end

  // State and registered-output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_ENTER_A;
      op_q     <= OP_ADD;
      result_q <= 16'h0000;
      err_q    <= 1'b0;
      disp_q   <= DISP_A;
      timer_q  <= TIMEOUT_LD;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      disp_q   <= disp_d;
      timer_q  <= timer_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign alu_start   = start_q;
  assign alu_op      = op_q;
  assign display_sel = disp_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: decimal-valued reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_calc_sequencer;

  localparam int TO = 10;
  localparam int M_A = 0, M_B = 1, M_START = 2, M_WAIT = 3, M_SHOW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = 16'h0000;
  logic        alu_ovf = 1'b0;
  logic        alu_start, alu_op, err, busy;
  logic [11:0] operand_a, operand_b;
  logic [15:0] result_q;
  logic [1:0]  display_sel;

  calc_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .alu_result(alu_result), .alu_ovf(alu_ovf),
    .alu_start(alu_start), .alu_op(alu_op), .operand_a(operand_a),
    .operand_b(operand_b), .result_q(result_q), .display_sel(display_sel),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int st; int a; int na; int b; int nb; int wt; int disp;
    logic [15:0] res; logic op; logic err;
  } model_t;

  model_t m;
  int  checks = 0, errors = 0, n_start = 0;
  bit  chk_en = 1'b0;
  bit  resp_rand = 1'b0;
  int  resp_delay = 4;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.st = M_A;
    return r;
  endfunction

  // One clock of calculator behaviour, operands held as plain decimal numbers.
  function automatic model_t model_next(input model_t c);
    model_t n;
    bit dig, opk, eqk, clr;
    int d;
    n   = c;
    dig = key_valid && (key_code <= 4'd9);
    opk = key_valid && (key_code == 4'hA || key_code == 4'hB);
    eqk = key_valid && (key_code == 4'hC);
    clr = key_valid && (key_code == 4'hD);
    d   = int'(key_code);
    if (reset) begin
      n = model_reset();
    end else if (clr) begin
      n.st = M_A; n.a = 0; n.na = 0; n.b = 0; n.nb = 0;
      n.err = 1'b0; n.op = 1'b0; n.disp = 0;
    end else begin
      case (c.st)
        M_A: begin
          if (dig) begin
            if (c.na < 3) begin n.a = c.a * 10 + d; n.na = c.na + 1; end
          end else if (opk) begin
            n.op = (key_code == 4'hB); n.b = 0; n.nb = 0; n.st = M_B;
          end
        end
        M_B: begin
          if (dig) begin
            if (c.nb < 3) begin n.b = c.b * 10 + d; n.nb = c.nb + 1; end
            n.disp = 1;
          end else if (opk) begin
            if (c.nb == 0) n.op = (key_code == 4'hB);
          end else if (eqk) begin
            n.st = M_START;
          end
        end
        M_START: begin n.st = M_WAIT; n.wt = 0; end
        M_WAIT: begin
          n.wt = c.wt + 1;
          if (alu_done) begin
            n.res = alu_result; n.err = alu_ovf; n.st = M_SHOW; n.disp = 2;
          end else if (n.wt >= TO) begin
            n.res = 16'h0000; n.err = 1'b1; n.st = M_SHOW; n.disp = 2;
          end
        end
        M_SHOW: begin
          if (dig) begin
            n.a = d; n.na = 1; n.b = 0; n.nb = 0; n.err = 1'b0; n.st = M_A; n.disp = 0;
          end
        end
        default: n = model_reset();
      endcase
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on the same edge the DUT registers do.
  initial begin
    m = model_reset();
    forever begin
      @(posedge clk);
      m = model_next(m);
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (alu_start === 1'b1) n_start++;
    if (chk_en) begin
      check("operand_a", 32'(operand_a), 32'(to_bcd(m.a)));
      check("operand_b", 32'(operand_b), 32'(to_bcd(m.b)));
      check("alu_op", 32'(alu_op), 32'(m.op));
      check("alu_start", 32'(alu_start), 32'(m.st == M_START));
      check("busy", 32'(busy), 32'(m.st == M_START || m.st == M_WAIT));
      check("result_q", 32'(result_q), 32'(m.res));
      check("display_sel", 32'(display_sel), 32'(m.disp));
      check("err", 32'(err), 32'(m.err));
    end
  end

  // ALU stand-in: answers after a chosen number of cycles, 0 meaning never.
  initial begin
    int pend, r, mag;
    logic [15:0] res;
    logic ovf;
    pend = 0; res = 16'h0000; ovf = 1'b0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      alu_ovf  = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            alu_done = 1'b1; alu_result = res; alu_ovf = ovf;
          end
        end
        if (alu_start) begin
          r   = alu_op ? from_bcd(operand_a) - from_bcd(operand_b)
                       : from_bcd(operand_a) + from_bcd(operand_b);
          mag = (r < 0) ? -r : r;
          res = {(r < 0), 3'b000, to_bcd(mag % 1000)};
          ovf = (mag > 999);
          pend = resp_rand ? int'($urandom_range(0, 11)) : resp_delay;
        end
      end
    end
  end

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'($urandom);
  endtask

  task automatic wait_start();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (alu_start === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    check("wait_start_found", 32'(found), 32'd1);
  endtask

  task automatic wait_show();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (display_sel === 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("wait_show_found", 32'(found), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n0, n, fin;
    int r, r2;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_operand_a", 32'(operand_a), 32'h0);
    check("rst_display_sel", 32'(display_sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;

    // 12 + 3 with a 4-cycle ALU.
    resp_rand = 1'b0; resp_delay = 4; n0 = n_start;
    key(4'd1); key(4'd2); key(4'hA); key(4'd3); key(4'hC);
    wait_start();
    check("d1_operand_a", 32'(operand_a), 32'h012);
    check("d1_operand_b", 32'(operand_b), 32'h003);
    check("d1_alu_op", 32'(alu_op), 32'd0);
    wait_show();
    check("d1_result_q", 32'(result_q), 32'h0015);
    check("d1_display_sel", 32'(display_sel), 32'd2);
    check("d1_err", 32'(err), 32'd0);
    check("d1_start_pulses", 32'(n_start - n0), 32'd1);

    // Fourth digit dropped, then 999 - 5.
    key(4'hD); key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    check("d2_operand_a", 32'(operand_a), 32'h999);
    key(4'hB); key(4'd5); key(4'hC);
    wait_start();
    check("d2_operand_b", 32'(operand_b), 32'h005);
    check("d2_alu_op", 32'(alu_op), 32'd1);
    wait_show();
    check("d2_result_q", 32'(result_q), 32'h0994);

    // 999 + 999 overflows; next digit starts fresh.
    key(4'hD); key(4'd9); key(4'd9); key(4'd9); key(4'hA); key(4'd9); key(4'd9); key(4'd9); key(4'hC);
    wait_start();
    wait_show();
    check("d3_err", 32'(err), 32'd1);
    check("d3_result_q", 32'(result_q), 32'h0998);
    key(4'd7);
    check("d3_err_after", 32'(err), 32'd0);
    check("d3_operand_a", 32'(operand_a), 32'h007);
    check("d3_display_sel", 32'(display_sel), 32'd0);

    // No ALU answer: SHOW after exactly TO waiting cycles.
    resp_delay = 0;
    key(4'hA); key(4'd2); key(4'hC);
    wait_start();
    n = 0; fin = 0;
    for (int i = 0; i < 40 && fin == 0; i++) begin
      @(negedge clk);
      if (busy) n++;
      else fin = 1;
    end
    check("d4_wait_cycles", 32'(n), 32'd10);
    check("d4_err", 32'(err), 32'd1);
    check("d4_result_q", 32'(result_q), 32'h0000);
    check("d4_display_sel", 32'(display_sel), 32'd2);

    // Clear two cycles after start; ALU reply lands one cycle later.
    resp_delay = 3;
    key(4'd4); key(4'hA); key(4'd5); key(4'hC);
    wait_start();
    @(negedge clk);
    key(4'hD);
    repeat (3) @(negedge clk);
    check("d5_display_sel", 32'(display_sel), 32'd0);
    check("d5_busy", 32'(busy), 32'd0);
    check("d5_result_q", 32'(result_q), 32'h0000);
    check("d5_operand_a", 32'(operand_a), 32'h000);

    // Reset while waiting on the ALU.
    resp_delay = 2;
    key(4'd2); key(4'hA); key(4'd3); key(4'hC);
    wait_start();
    wait_show();
    check("d6_result_q", 32'(result_q), 32'h0005);
    resp_delay = 0;
    key(4'd1); key(4'hB); key(4'd1); key(4'hC);
    wait_start();
    @(negedge clk); @(negedge clk);
    check("d6_busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("d6_rst_result_q", 32'(result_q), 32'h0000);
    check("d6_rst_operand_a", 32'(operand_a), 32'h000);
    check("d6_rst_operand_b", 32'(operand_b), 32'h000);
    check("d6_rst_alu_op", 32'(alu_op), 32'd0);
    check("d6_rst_busy", 32'(busy), 32'd0);
    check("d6_rst_alu_start", 32'(alu_start), 32'd0);
    check("d6_rst_err", 32'(err), 32'd0);
    check("d6_rst_display_sel", 32'(display_sel), 32'd0);

    // Randomized key traffic with random ALU latency (including no reply).
    resp_rand = 1'b1;
    for (int it = 0; it < 700; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
      end else begin
        r2 = int'($urandom_range(0, 99));
        if (r2 < 55)      key(4'($urandom_range(0, 9)));
        else if (r2 < 70) key(($urandom_range(0, 1) == 0) ? 4'hA : 4'hB);
        else if (r2 < 84) key(4'hC);
        else if (r2 < 90) key(4'hD);
        else              key(($urandom_range(0, 1) == 0) ? 4'hE : 4'hF);
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have ports: clk in 1, system clock; reset in 1, synchronous, active-high reset.
REQ-002 SHALL have key_valid in 1: one-cycle pulse, key_code valid.
REQ-003 SHALL have key_code in 4: 0-9 digit, 0xA add, 0xB sub, 0xC equals, 0xD clear; 0xE/0xF ignored.
REQ-004 SHALL have alu_done in 1: one-cycle pulse, ALU result valid.
REQ-005 SHALL have alu_result in 16: ALU result, bit15 sign, bits11:0 three BCD digits.
REQ-006 SHALL have alu_ovf in 1: qualified by alu_done, result exceeds 999.
REQ-007 SHALL have alu_start out 1: one-cycle pulse, operands and op stable.
REQ-008 SHALL have alu_op out 1: 0 add, 1 sub.
REQ-009 SHALL have operand_a out 12: operand A, BCD.
REQ-010 SHALL have operand_b out 12: operand B, BCD.
REQ-011 SHALL have result_q out 16: latched ALU result.
REQ-012 SHALL have display_sel out 2: 0 show A, 1 show B, 2 show result.
REQ-013 SHALL have err out 1: overflow or ALU timeout flag.
REQ-014 SHALL have busy out 1: high in START and WAIT_ALU.
REQ-015 SHALL have parameter TIMEOUT, default 255: alu_done wait limit in cycles.

Function
REQ-016 SHALL implement states ENTER_A, ENTER_B, START, WAIT_ALU, SHOW; all outputs registered.
REQ-017 ENTER_A, digit: shift left one BCD digit into A if A count <3, else ignore; display_sel=0.
REQ-018 ENTER_A, add/sub: latch alu_op, clear B, go ENTER_B; A with zero digits counts as 000.
REQ-019 ENTER_A, equals: ignored.
REQ-020 ENTER_B, digit: shift into B, same 3-digit limit; display_sel=1 from the first B digit, 0 before it.
REQ-021 ENTER_B, add/sub: replace alu_op only while B count=0, else ignore.
REQ-022 ENTER_B, equals: go START; empty B counts as 000.
REQ-023 START: alu_start=1 for exactly one cycle, then WAIT_ALU.
REQ-024 operand_a, operand_b, alu_op SHALL hold constant from START until leaving WAIT_ALU.
REQ-025 WAIT_ALU, alu_done: latch alu_result into result_q and alu_ovf into err, go SHOW, display_sel=2.
REQ-026 WAIT_ALU: down-counter loaded with TIMEOUT on entry; at zero, err=1, result_q=0, go SHOW.
REQ-027 WAIT_ALU: digit, op and equals keys ignored.
REQ-028 SHOW, digit: clear A and B, clear err, load digit into A, go ENTER_A.
REQ-029 SHOW: op and equals keys ignored.
REQ-030 Clear key in any state: A=B=0, counts=0, err=0, alu_op=0, result_q kept, go ENTER_A.
REQ-031 Clear during WAIT_ALU aborts; a later stale alu_done SHALL be ignored in any state other than WAIT_ALU.
REQ-032 key_valid and alu_done in the same WAIT_ALU cycle: clear wins, otherwise alu_done processed and key dropped.
REQ-033 Key-to-state latency SHALL be one cycle: key in cycle n, registers updated at edge n+1.

Reset
REQ-034 On reset: state ENTER_A, A=B=0, digit counts=0, result_q=0, alu_op=0, alu_start=0, err=0, busy=0, display_sel=0, timeout counter=TIMEOUT.
REQ-035 Reset SHALL override all other inputs in the same cycle, including mid-WAIT_ALU.

Structure
REQ-036 Package calc_pkg SHALL hold the key-code constants, the state enum, the op encoding and the display_sel encoding.
REQ-037 Sub-module calc_digit_reg SHALL implement a 3-digit BCD shift register with 2-bit count, load/clear/shift controls and saturate-ignore at 3 digits; it SHALL be instantiated for A and for B.

Verification
REQ-038 Keys 1,2,add,3,equals; ALU model answers 015 after 4 cycles -> alu_start pulse once with A=012, B=003, op=0; result_q=0x0015, display_sel=2, err=0.
REQ-039 Digits 9,9,9,9 -> A=999, fourth digit ignored; then sub,5,equals -> operand_b=005, alu_op=1.
REQ-040 ALU asserts alu_ovf with done -> err=1 in SHOW; next digit 7 -> err=0, A=007, ENTER_A.
REQ-041 No alu_done with TIMEOUT=10 -> err=1, state SHOW exactly 10 cycles after entering WAIT_ALU.
REQ-042 Clear two cycles after alu_start, alu_done arriving one cycle later -> ENTER_A, result_q unchanged, stale done ignored.
REQ-043 Reset asserted in WAIT_ALU -> every output at its REQ-034 value on the next cycle.
